ln_fixed_seq: RTL and testbench

// - Sequential natural-log unit: the inverse of the exponential block. Takes unsigned Q16.16 x,

---
 rtl/ln_fixed_seq.sv | 151 +++++++++++++++
 tb/tb_ln_fixed_seq.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/ln_fixed_seq.sv
// Sequential ln(x): unsigned Q16.16 in, signed Q16.16 out via bit-serial log2 and ln2 scale; optional out_log2 port under LN_LOG2_OUT_EN.
// Latency: out_valid rises FRAC_BITS+2 edges after the accepting edge; one operand in flight, FRAC_BITS+4 cycles per op.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready, in_valid while busy is ignored.
module ln_fixed_seq #(
    parameter int FRAC_BITS = 16,
    parameter int LN2_Q16   = 45426
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_x,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_ln,
`ifdef LN_LOG2_OUT_EN
    output logic [31:0] out_log2,
`endif
    output logic        out_err
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        NORM  = 3'd1,
        ITER  = 3'd2,
        SCALE = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [16:0] LN2_K    = LN2_Q16[16:0];
    localparam logic [4:0]  CNT_LAST = 5'(FRAC_BITS - 1);

    state_t      state, state_nxt;
    logic [31:0] x_r;
    logic [31:0] m_r;
    logic [31:0] log2_r;
    logic [4:0]  cnt;
    logic        err_r;
    logic [31:0] ln_r;
    logic [31:0] log2_out_r;
    logic        err_out_r;

    // Index of the most significant set bit, expressed as a leading-zero count.
    function automatic logic [4:0] lzc(input logic [31:0] v);
        logic [4:0] r;
        r = 5'd31;
        for (int i = 0; i < 32; i++) begin
            if (v[i]) r = 5'(31 - i);
        end
        return r;
    endfunction

    logic [4:0]         lz;
    logic [63:0]        sq;
    logic signed [48:0] prod_a;
    logic signed [48:0] prod_b;
    logic signed [48:0] prod;

    assign lz     = lzc(x_r);
    assign sq     = {32'd0, m_r} * {32'd0, m_r};
    assign prod_a = {{17{log2_r[31]}}, log2_r};
    assign prod_b = {32'd0, LN2_K};
    assign prod   = prod_a * prod_b;

    logic unused_bits;
    assign unused_bits = ^{sq[30:0], prod[48], prod[15:0]};

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = NORM;
            end
            NORM:  state_nxt = ITER;
            ITER:  if (cnt == CNT_LAST) state_nxt = SCALE;
            SCALE: state_nxt = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_r        <= '0;
            m_r        <= '0;
            log2_r     <= '0;
            cnt        <= '0;
            err_r      <= 1'b0;
            ln_r       <= '0;
            log2_out_r <= '0;
            err_out_r  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) x_r <= in_x;
                end
                NORM: begin
                    // k = 15 - lz; unsigned wraparound yields the two's-complement integer part.
                    m_r    <= x_r << lz;
                    log2_r <= (32'd15 - {27'd0, lz}) << 16;
                    cnt    <= '0;
                    err_r  <= (x_r == 32'd0);
                end
                ITER: begin
                    if (sq[63]) begin
                        m_r    <= sq[63:32];
                        log2_r <= log2_r | (32'h0000_8000 >> cnt);
                    end else begin
                        m_r <= sq[62:31];
                    end
                    cnt <= cnt + 5'd1;
                end
                SCALE: begin
                    err_out_r <= err_r;
                    if (err_r) begin
                        ln_r       <= 32'h8000_0000;
                        log2_out_r <= 32'h8000_0000;
                    end else begin
                        ln_r       <= prod[47:16];
                        log2_out_r <= log2_r;
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_ln  = ln_r;
    assign out_err = err_out_r;
`ifdef LN_LOG2_OUT_EN
    assign out_log2 = log2_out_r;
`else
    logic unused_log2;
    assign unused_log2 = ^log2_out_r;
`endif

endmodule

// File: tb/tb_ln_fixed_seq.sv
// Directed and random operands for ln_fixed_seq, checked against a queue of expected results.
module tb_ln_fixed_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_x = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_ln;
    logic        out_err;
`ifdef LN_LOG2_OUT_EN
    logic [31:0] out_log2;
`endif

    ln_fixed_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ln    (out_ln),
`ifdef LN_LOG2_OUT_EN
        .out_log2  (out_log2),
`endif
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] ln;
        logic [31:0] l2;
        logic        err;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Reference: normalise by shifting, then square-and-compare 16 times.
    function automatic exp_t model(input logic [31:0] x);
        exp_t        r;
        logic [31:0] m;
        logic [63:0] p;
        longint      l2;
        longint      pr;
        int          e;
        if (x == 32'd0) begin
            r.ln  = 32'h8000_0000;
            r.l2  = 32'h8000_0000;
            r.err = 1'b1;
            return r;
        end
        m = x;
        e = 15;
        while (m[31] == 1'b0) begin
            m = m << 1;
            e--;
        end
        l2 = longint'(e) * 65536;
        for (int i = 1; i <= 16; i++) begin
            p = {32'd0, m} * {32'd0, m};
            if (p[63]) begin
                l2 = l2 + (longint'(1) << (16 - i));
                m  = p[63:32];
            end else begin
                m = p[62:31];
            end
        end
        pr    = l2 * 45426;
        r.ln  = 32'(pr >>> 16);
        r.l2  = 32'(l2);
        r.err = 1'b0;
        return r;
    endfunction

    task automatic send(input logic [31:0] x, input exp_t e);
        @(negedge clk);
        chk("in_ready_idle", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        in_x     = x;
        sb.push_back(e);
        @(posedge clk);
    endtask

    // Waits for the result, checks latency and value, optionally stalls the consumer.
    task automatic collect(input string tag, input int hold);
        exp_t e;
        int   n;
        n = 0;
        while (1) begin
            @(negedge clk);
            in_valid = 1'b0;
            if (out_valid) break;
            if (n >= 60) break;
            @(posedge clk);
            n++;
        end
        chk({tag, "_latency"}, 32'(n), 32'd18);
        if (!out_valid || sb.size() == 0) return;
        e = sb.pop_front();
        chk({tag, "_ln"}, out_ln, e.ln);
        chk({tag, "_err"}, {31'd0, out_err}, {31'd0, e.err});
`ifdef LN_LOG2_OUT_EN
        chk({tag, "_log2"}, out_log2, e.l2);
`endif
        if (hold > 0) begin
            in_valid = 1'b1;
            in_x     = 32'hDEAD_BEEF;
            repeat (hold) begin
                @(posedge clk);
                @(negedge clk);
                chk({tag, "_held_ln"}, out_ln, e.ln);
                chk({tag, "_held_valid"}, {31'd0, out_valid}, 32'd1);
                chk({tag, "_held_in_ready"}, {31'd0, in_ready}, 32'd0);
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_valid_drop"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_in_ready_back"}, {31'd0, in_ready}, 32'd1);
    endtask

    task automatic run_const(input string tag, input logic [31:0] x,
                             input logic [31:0] ln, input logic err);
        exp_t e;
        e     = model(x);
        e.ln  = ln;
        e.err = err;
        send(x, e);
        collect(tag, 0);
    endtask

    initial begin
        exp_t        e;
        logic [31:0] rx;

        repeat (2) @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_ln", out_ln, 32'd0);
        chk("rst_out_err", {31'd0, out_err}, 32'd0);
        rst_n = 1'b1;

        run_const("one",     32'h0001_0000, 32'h0000_0000, 1'b0);
        run_const("two",     32'h0002_0000, 32'h0000_B172, 1'b0);
        run_const("four",    32'h0004_0000, 32'h0001_62E4, 1'b0);
        run_const("half",    32'h0000_8000, 32'hFFFF_4E8E, 1'b0);
        run_const("zero",    32'h0000_0000, 32'h8000_0000, 1'b1);
        run_const("min_lsb", 32'h0000_0001, 32'hFFF4_E8E0, 1'b0);
`ifdef LN_LOG2_OUT_EN
        chk("half_log2_const", model(32'h0000_8000).l2, 32'hFFFF_0000);
`endif

        send(32'hFFFF_FFFF, model(32'hFFFF_FFFF));
        collect("max", 0);
        for (int i = 0; i < 6; i++) begin
            rx = $urandom;
            rx = rx >> $urandom_range(0, 24);
            if (rx == 32'd0) rx = 32'd3;
            send(rx, model(rx));
            collect("random", 0);
        end

        // Consumer stalls in DONE while a new operand is offered and must be ignored.
        out_ready = 1'b0;
        e     = model(32'h0004_0000);
        e.ln  = 32'h0001_62E4;
        send(32'h0004_0000, e);
        collect("backpressure", 5);
        repeat (3) @(negedge clk);
        chk("ignored_op_no_output", {31'd0, out_valid}, 32'd0);
        chk("ignored_op_idle", {31'd0, in_ready}, 32'd1);

        // Reset mid-iteration discards the operand.
        send(32'h0003_0000, model(32'h0003_0000));
        void'(sb.pop_back());
        repeat (5) @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_out_ln", out_ln, 32'd0);
        chk("midrst_out_err", {31'd0, out_err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_const("after_rst_two", 32'h0002_0000, 32'h0000_B172, 1'b0);

        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
